serial_frame_builder: RTL and testbench

//  Upstream stage of the serial transmitter: turns one parallel request (port, length, payload) into the SerIn bit stream.

---
 rtl/sfb_pkg.sv | 31 +++
 rtl/sfb_shreg.sv | 31 +++
 rtl/serial_frame_builder.sv | 201 ++++++++++++++++++++
 tb/tb_serial_frame_builder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sfb_pkg.sv
// sfb_pkg: shared state encoding, field-width defaults and frame-length helper for serial_frame_builder.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Build option: define SFB_PARITY_EN to add one even-parity bit ahead of the guard bit.
package sfb_pkg;

  localparam int SFB_ADDR_W = 2;
  localparam int SFB_LEN_W  = 4;
  localparam int SFB_DATA_W = 15;

`ifdef SFB_PARITY_EN
  localparam int SFB_PAR_BITS = 1;
`else
  localparam int SFB_PAR_BITS = 0;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADDR  = 3'd2,
    LEN   = 3'd3,
    DATA  = 3'd4,
    PAR   = 3'd5,
    GUARD = 3'd6
  } sfb_state_t;

  // Total bit periods on the line for one frame carrying `len` payload bits.
  function automatic int frame_bits(input int len);
    return 1 + SFB_ADDR_W + SFB_LEN_W + len + SFB_PAR_BITS + 1;
  endfunction

endpackage

// File: rtl/sfb_shreg.sv
// sfb_shreg: loadable shift register presenting its next outgoing bit on `head`, MSB- or LSB-first.
// Latency: load/shift take effect on the next clk edge; head is a mux of flop outputs.
// Backpressure: none; shifts only when shift_en is high (caller qualifies it with bit_en).
// Ports: clk, rst (async active-low), load/load_val, shift_en, msb_first, head.
module sfb_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift_en,
  input  logic         msb_first,
  output logic         head
);

  logic [W-1:0] q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift_en) begin
      q <= msb_first ? {q[W-2:0], 1'b0} : {1'b0, q[W-1:1]};
    end
  end

  assign head = msb_first ? q[W-1] : q[0];

endmodule

// File: rtl/serial_frame_builder.sv
// serial_frame_builder: serialises one {port, length, payload} request into start/addr/len/data/guard bits.
// Latency: start bit on the line the clk after accept; every later bit is one bit_en period long.
// Backpressure: ready only in IDLE (and not in the done cycle); req while busy is ignored.
// Ports: clk, rst (async active-low), bit_en, req, port_sel, length, data -> ready, ser_out (registered), busy, done.
// Build option: SFB_PARITY_EN inserts an even-parity bit (port, length, sent payload bits) before the guard bit.
module serial_frame_builder
  import sfb_pkg::*;
#(
  parameter int ADDR_W = SFB_ADDR_W,
  parameter int LEN_W  = SFB_LEN_W,
  parameter int DATA_W = SFB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              req,
  input  logic [ADDR_W-1:0] port_sel,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              ser_out,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = LEN_W + 1;

  sfb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;     // bits left in the current field after the one on the line
  logic             ser_q, ser_d;
  logic             done_q, done_d;
  logic [LEN_W-1:0] len_q;
  logic             accept;
  logic             hdr_head, dat_head;
  logic             hdr_shift, dat_shift;
  logic             tail;

  assign ready   = (state_q == IDLE) && !done_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign ser_out = ser_q;
  assign accept  = req && ready;

  // Port and length are contiguous on the line and both MSB-first, so one register serves both fields.
  sfb_shreg #(.W(ADDR_W + LEN_W)) u_hdr_sr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val ({port_sel, length}),
    .shift_en (hdr_shift),
    .msb_first(1'b1),
    .head     (hdr_head)
  );

  sfb_shreg #(.W(DATA_W)) u_dat_sr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (data),
    .shift_en (dat_shift),
    .msb_first(1'b0),
    .head     (dat_head)
  );

`ifdef SFB_PARITY_EN
  logic par_calc;
  logic par_q;

  // Only payload bits that will actually be sent contribute to parity.
  always_comb begin
    par_calc = ^{port_sel, length};
    for (int i = 0; i < DATA_W; i++) begin
      if (i < int'(length)) par_calc = par_calc ^ data[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par_q <= 1'b0;
    else if (accept) par_q <= par_calc;
  end
`endif

  // Each transition puts the first bit of the next field on the line at the same edge,
  // so ser_out stays a plain flop and every bit spans exactly one bit_en period.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ser_d     = ser_q;
    done_d    = 1'b0;
    hdr_shift = 1'b0;
    dat_shift = 1'b0;
    tail      = 1'b0;

    case (state_q)
      IDLE: begin
        ser_d = 1'b1;
        if (accept) begin
          state_d = START;
          cnt_d   = '0;
          ser_d   = 1'b0;
        end
      end
      START: begin
        if (bit_en) begin
          state_d   = ADDR;
          cnt_d     = CNT_W'(ADDR_W - 1);
          ser_d     = hdr_head;
          hdr_shift = 1'b1;
        end
      end
      ADDR: begin
        if (bit_en) begin
          ser_d     = hdr_head;
          hdr_shift = 1'b1;
          if (cnt_q == '0) begin
            state_d = LEN;
            cnt_d   = CNT_W'(LEN_W - 1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      LEN: begin
        if (bit_en) begin
          if (cnt_q != '0) begin
            ser_d     = hdr_head;
            hdr_shift = 1'b1;
            cnt_d     = cnt_q - CNT_W'(1);
          end else if (len_q != '0) begin
            state_d   = DATA;
            cnt_d     = {1'b0, len_q} - CNT_W'(1);
            ser_d     = dat_head;
            dat_shift = 1'b1;
          end else begin
            tail = 1'b1;
          end
        end
      end
      DATA: begin
        if (bit_en) begin
          if (cnt_q != '0) begin
            ser_d     = dat_head;
            dat_shift = 1'b1;
            cnt_d     = cnt_q - CNT_W'(1);
          end else begin
            tail = 1'b1;
          end
        end
      end
      PAR: begin
        if (bit_en) begin
          state_d = GUARD;
          cnt_d   = '0;
          ser_d   = 1'b1;
        end
      end
      GUARD: begin
        if (bit_en) begin
          state_d = IDLE;
          cnt_d   = '0;
          ser_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        ser_d   = 1'b1;
      end
    endcase

    // Common exit after the last header/payload bit.
    if (tail) begin
      cnt_d = '0;
`ifdef SFB_PARITY_EN
      state_d = PAR;
      ser_d   = par_q;
`else
      state_d = GUARD;
      ser_d   = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ser_q   <= 1'b1;
      done_q  <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ser_q   <= ser_d;
      done_q  <= done_d;
      if (accept) len_q <= length;
    end
  end

endmodule

// File: tb/tb_serial_frame_builder.sv
// tb_serial_frame_builder: directed stimulus with a bit-level scoreboard for serial_frame_builder.
// Expected line bits are queued when a request is driven and popped as each bit period closes.
// Honours SFB_PARITY_EN the same way the design does.
module tb_serial_frame_builder;

  localparam int ADDR_W = 2;
  localparam int LEN_W  = 4;
  localparam int DATA_W = 15;
`ifdef SFB_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              bit_en;
  logic              req;
  logic [ADDR_W-1:0] port_sel;
  logic [LEN_W-1:0]  length;
  logic [DATA_W-1:0] data;
  logic              ready;
  logic              ser_out;
  logic              busy;
  logic              done;

  int checks   = 0;
  int failures = 0;
  int per      = 1;
  int ph       = 0;
  bit exp_q[$];

  serial_frame_builder #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bit_en  (bit_en),
    .req     (req),
    .port_sel(port_sel),
    .length  (length),
    .data    (data),
    .ready   (ready),
    .ser_out (ser_out),
    .busy    (busy),
    .done    (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then set bit_en for the cycle that follows.
  task automatic clk_step();
    @(negedge clk);
    ph     = (ph + 1 >= per) ? 0 : ph + 1;
    bit_en = (ph == per - 1);
  endtask

  task automatic push_frame(input logic [ADDR_W-1:0] p, input logic [LEN_W-1:0] l,
                            input logic [DATA_W-1:0] d);
    int ones = 0;
    exp_q.push_back(1'b0);
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      exp_q.push_back(p[i]);
      ones += int'(p[i]);
    end
    for (int i = LEN_W - 1; i >= 0; i--) begin
      exp_q.push_back(l[i]);
      ones += int'(l[i]);
    end
    for (int i = 0; i < int'(l); i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (PAR_EN) exp_q.push_back(ones[0]);
    exp_q.push_back(1'b1);
  endtask

  // Drive a request in the current cycle; returns at the falling edge after the accept edge.
  task automatic launch(input string tag, input logic [ADDR_W-1:0] p, input logic [LEN_W-1:0] l,
                        input logic [DATA_W-1:0] d, input bit hold);
    chk({tag, "_ready_pre"}, ready, 1);
    port_sel = p;
    length   = l;
    data     = d;
    req      = 1'b1;
    push_frame(p, l, d);
    clk_step();
    if (!hold) req = 1'b0;
  endtask

  // Compare the line every clk until the scoreboard drains, then check the done cycle.
  task automatic run_frame(input string tag, input bit poke);
    int budget = 0;
    int hold   = 0;
    bit first  = 1'b1;
    while (exp_q.size() > 0 && budget < 4000) begin
      chk({tag, "_ser"}, ser_out, exp_q[0]);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_ready_busy"}, ready, 0);
      chk({tag, "_done_early"}, done, 0);
      if (poke) begin
        req      = (exp_q.size() > 3 && exp_q.size() < 10);
        port_sel = ADDR_W'($urandom);
        length   = LEN_W'($urandom);
        data     = DATA_W'($urandom);
      end
      hold++;
      if (bit_en) begin
        if (!first) chk({tag, "_hold"}, hold, per);
        first = 1'b0;
        hold  = 0;
        void'(exp_q.pop_front());
      end
      clk_step();
      budget++;
    end
    chk({tag, "_bits_left"}, exp_q.size(), 0);
    exp_q.delete();
    if (poke) req = 1'b0;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_ready_done"}, ready, 0);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_ser_done"}, ser_out, 1);
  endtask

  task automatic after_done(input string tag);
    clk_step();
    chk({tag, "_done_clr"}, done, 0);
    chk({tag, "_ready_idle"}, ready, 1);
    chk({tag, "_ser_idle"}, ser_out, 1);
  endtask

  initial begin
    rst      = 1'b1;
    bit_en   = 1'b0;
    req      = 1'b0;
    port_sel = '0;
    length   = '0;
    data     = '0;
    #1 rst = 1'b0;
    #1;
    chk("reset_ser", ser_out, 1);
    chk("reset_ready", ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    per    = 1;
    ph     = 0;
    bit_en = 1'b1;

    // bit_en every clk, payload 101
    launch("t1", 2'b10, 4'd3, 15'h0005, 1'b0);
    run_frame("t1", 1'b0);
    after_done("t1");

    // zero-length payload, data must be ignored
    launch("t2", 2'b01, 4'd0, 15'h7fff, 1'b0);
    run_frame("t2", 1'b0);
    after_done("t2");

    // bit_en every 4th clk, requests poked while busy
    per    = 4;
    ph     = 0;
    bit_en = 1'b0;
    launch("t3", 2'b11, 4'd5, 15'h001a, 1'b0);
    run_frame("t3", 1'b1);
    after_done("t3");

    // back-to-back with req held high; inputs changed mid-frame feed the second frame only
    per    = 1;
    ph     = 0;
    bit_en = 1'b1;
    launch("t4a", 2'b01, 4'd2, 15'h0002, 1'b1);
    port_sel = 2'b10;
    length   = 4'd4;
    data     = 15'h0009;
    run_frame("t4a", 1'b0);
    clk_step();
    chk("t4_gap_ready", ready, 1);
    chk("t4_gap_busy", busy, 0);
    chk("t4_gap_ser", ser_out, 1);
    push_frame(2'b10, 4'd4, 15'h0009);
    clk_step();
    req = 1'b0;
    run_frame("t4b", 1'b0);
    after_done("t4b");

    // parity case (parity bit only present with SFB_PARITY_EN)
    launch("t5", 2'b11, 4'd2, 15'h0003, 1'b0);
    run_frame("t5", 1'b0);
    after_done("t5");

    // asynchronous reset in the middle of a frame
    launch("t6", 2'b10, 4'd7, 15'h0055, 1'b0);
    repeat (3) clk_step();
    chk("t6_ser_pre", ser_out, 0);
    chk("t6_busy_pre", busy, 1);
    exp_q.delete();
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_ser", ser_out, 1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ready", ready, 1);
    chk("t6_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    clk_step();
    chk("t6_post_done", done, 0);
    chk("t6_post_ser", ser_out, 1);
    chk("t6_post_ready", ready, 1);

    // clean frame after the abort
    launch("t7", 2'b00, 4'd1, 15'h0001, 1'b0);
    run_frame("t7", 1'b0);
    after_done("t7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
